// File: rtl/cripto_ctrl_pkg.sv
// Shared types and sizes for the cipher-core block controller.
package cripto_ctrl_pkg;

  localparam int BLOCK_BYTES = 8;
  localparam int KEY_WORDS   = 8;
  localparam int BLOCK_W     = 64;
  localparam int KEY_W       = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/cripto_ctrl_ser.sv
// Result serialiser: presents a 64-bit word as 8 bytes, MSB first, on a
// valid/ready stream. The word must stay stable while the stream is active.
module cripto_ctrl_ser
  import cripto_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [BLOCK_W-1:0] data_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [7:0]         data_o,
  output logic               last_o
);

  logic       active_q, active_d;
  logic [2:0] cnt_q, cnt_d;
  logic       fire;

  assign fire    = active_q & ready_i;
  assign last_o  = fire & (cnt_q == 3'(BLOCK_BYTES - 1));
  assign valid_o = active_q;
  assign data_o  = data_i[{~cnt_q, 3'b000} +: 8];

  // Next byte index and activity: start arms the stream, the 8th handshake ends it.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = 3'd0;
    end else if (fire) begin
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'(BLOCK_BYTES - 1)) begin
        active_d = 1'b0;
      end
    end
  end

  // Serialiser state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      cnt_q    <= 3'd0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/cripto_ctrl.sv
// Cipher-core controller: packs 8 input bytes into a block, launches the
// core, waits for its result with a timeout, and streams the result out.
module cripto_ctrl
  import cripto_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [7:0]         out_data,
  input  logic               out_ready,
  input  logic               enc_dec,
  input  logic               key_we,
  input  logic [2:0]         key_addr,
  input  logic [31:0]        key_word,
  output logic               core_start,
  output logic               core_enc_dec,
  output logic [BLOCK_W-1:0] core_data,
  output logic [KEY_W-1:0]   core_key,
  input  logic               core_busy,
  input  logic               core_ready,
  input  logic [BLOCK_W-1:0] core_result,
  output logic               busy,
  output logic               err
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [2:0]         in_cnt_q, in_cnt_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [BLOCK_W-1:0] result_q, result_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               mode_q, mode_d;
  logic               err_q, err_d;

  logic in_open, in_fire, last_in, res_take, ser_last;

  // Input side and key register are only open while collecting a block.
  assign in_open  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign in_ready = in_open && !reset;
  assign in_fire  = in_valid && in_ready;
  assign last_in  = in_fire && (in_cnt_q == 3'(BLOCK_BYTES - 1));
  assign res_take = (state_q == ST_WAIT) && core_ready;

  assign core_start   = (state_q == ST_START) && !core_busy;
  assign core_enc_dec = mode_q;
  assign core_data    = block_q;
  assign core_key     = key_q;
  assign busy         = (state_q != ST_IDLE);
  assign err          = err_q;

  // Next state, WAIT cycle counter and timeout error; ready beats timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE:  if (in_fire) state_d = ST_LOAD;
      ST_LOAD:  if (last_in) state_d = ST_START;
      ST_START: if (!core_busy) state_d = ST_WAIT;
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        if (core_ready) begin
          state_d = ST_DRAIN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: if (ser_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: MSB-first byte packing, mode sampling, result capture, key writes.
  always_comb begin
    block_d  = block_q;
    in_cnt_d = in_cnt_q;
    if (in_fire) begin
      block_d[{~in_cnt_q, 3'b000} +: 8] = in_data;
      in_cnt_d = in_cnt_q + 3'd1;
    end
    mode_d   = last_in ? enc_dec : mode_q;
    result_d = res_take ? core_result : result_q;
    key_d    = key_q;
    if (key_we && in_open) begin
      key_d[{~key_addr, 5'b00000} +: 32] = key_word;
    end
  end

  // All controller state; reset discards any partial block, result and key.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      in_cnt_q   <= 3'd0;
      wait_cnt_q <= '0;
      block_q    <= '0;
      result_q   <= '0;
      key_q      <= '0;
      mode_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      block_q    <= block_d;
      result_q   <= result_d;
      key_q      <= key_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
    end
  end

  cripto_ctrl_ser u_ser (
    .clk_i   (clock),
    .rst_i   (reset),
    .start_i (res_take),
    .data_i  (result_q),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .last_o  (ser_last)
  );

endmodule

// File: tb/tb_cripto_ctrl.sv
// Testbench for cripto_ctrl with a behavioural cipher core and reference model.
module tb_cripto_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_ready = 1'b1;
  logic         enc_dec = 1'b0;
  logic         key_we = 1'b0;
  logic [2:0]   key_addr = 3'd0;
  logic [31:0]  key_word = 32'h0;
  logic         core_start;
  logic         core_enc_dec;
  logic [63:0]  core_data;
  logic [255:0] core_key;
  logic         core_busy = 1'b0;
  logic         core_ready = 1'b0;
  logic [63:0]  core_result = 64'h0;
  logic         busy;
  logic         err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // behavioural core state
  int           core_lat = 0;
  bit           core_mute = 1'b0;
  bit           pend = 1'b0;
  int           cd = 0;
  logic [63:0]  c_data;
  logic [255:0] c_key;
  logic         c_mode;

  // observation state
  int           starts = 0;
  int           start_cyc = 0;
  int           errs = 0;
  int           err_cyc = 0;
  logic         err_busy = 1'b0;
  bit           ov_seen = 1'b0;
  logic [63:0]  st_data = 64'h0;
  logic [255:0] st_key = 256'h0;
  logic         st_mode = 1'b0;

  logic [31:0]  kmodel [8];

  cripto_ctrl #(.TIMEOUT(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .enc_dec      (enc_dec),
    .key_we       (key_we),
    .key_addr     (key_addr),
    .key_word     (key_word),
    .core_start   (core_start),
    .core_enc_dec (core_enc_dec),
    .core_data    (core_data),
    .core_key     (core_key),
    .core_busy    (core_busy),
    .core_ready   (core_ready),
    .core_result  (core_result),
    .busy         (busy),
    .err          (err)
  );

  always #5 clock = ~clock;

  // Toy invertible cipher used by the behavioural core.
  function automatic logic [63:0] cipher(input logic [63:0] d, input logic [255:0] k, input logic m);
    logic [63:0] kf, ks;
    kf = k[255:192] ^ k[191:128] ^ k[127:64] ^ k[63:0];
    ks = {kf[31:0], kf[63:32]};
    return m ? ((d ^ kf) + ks) : ((d - ks) ^ kf);
  endfunction

  function automatic logic [255:0] key_vec();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[255 - 32*i -: 32] = kmodel[i];
    return v;
  endfunction

  always @(negedge clock) begin
    cyc++;
    if (core_start) begin
      starts++;
      start_cyc = cyc;
      st_data = core_data;
      st_key = core_key;
      st_mode = core_enc_dec;
    end
    if (err) begin
      errs++;
      err_cyc = cyc;
      err_busy = busy;
    end
    if (out_valid) ov_seen = 1'b1;
  end

  // Core: result appears core_lat+1 cycles after the start pulse.
  always @(negedge clock) begin
    core_ready = 1'b0;
    if (pend) begin
      if (cd == 0) begin
        pend = 1'b0;
        core_result = cipher(c_data, c_key, c_mode);
        core_ready = !core_mute;
      end else begin
        cd--;
      end
    end
    if (core_start) begin
      pend = 1'b1;
      cd = core_lat;
      c_data = core_data;
      c_key = core_key;
      c_mode = core_enc_dec;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    key_we = 1'b0;
    core_busy = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) kmodel[i] = 32'h0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    in_valid = 1'b1;
    in_data = b;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] blk, input logic mode);
    bit ok, all;
    all = 1'b1;
    enc_dec = mode;
    for (int i = 0; i < 8; i++) begin
      send_byte(blk[63 - 8*i -: 8], ok);
      all = all & ok;
    end
    checks++;
    if (!all) begin
      failures++;
      $display("FAIL send_block in_ready never rose, block=%h", blk);
    end
  endtask

  task automatic write_key(input logic [2:0] a, input logic [31:0] w, input bit upd);
    key_we = 1'b1;
    key_addr = a;
    key_word = w;
    @(posedge clock);
    #1 key_we = 1'b0;
    if (upd) kmodel[a] = w;
  endtask

  // rmode: 0 = always ready, 1 = toggle 1010, 2 = random
  task automatic recv_block(input int rmode, output logic [63:0] v, output int first);
    int n;
    bit stalled, rdy, ok;
    logic [7:0] held;
    n = 0; stalled = 1'b0; rdy = 1'b1; ok = 1'b0; held = 8'h0; v = '0; first = -1;
    for (int i = 0; i < 400; i++) begin
      out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : rdy;
      @(negedge clock);
      if (out_valid) begin
        if (first < 0) first = i;
        if (stalled) begin
          checks++;
          if (out_data !== held) begin
            failures++;
            $display("FAIL out_hold got=%h want=%h", out_data, held);
          end
        end
        if (out_ready) begin
          v = {v[55:0], out_data};
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end
      @(posedge clock);
      #1;
      if (rmode == 1) rdy = ~rdy;
      if (n == 8) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL recv_block got %0d of 8 bytes", n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_during got=%b want=0", in_ready); end
    do_reset();
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready_after got=%b want=1", in_ready); end
    checks++;
    if ({out_valid, core_start, busy, err, core_enc_dec} !== 5'b0) begin
      failures++;
      $display("FAIL rst_outputs got ov/cs/busy/err/mode=%b want=00000",
               {out_valid, core_start, busy, err, core_enc_dec});
    end
    checks++;
    if (core_key !== 256'h0 || core_data !== 64'h0) begin
      failures++;
      $display("FAIL rst_regs got key=%h data=%h want 0", core_key, core_data);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_known(output logic [63:0] res);
    logic [255:0] kc;
    logic [63:0] v, blk;
    int s0, first;
    kc = 256'hDEADBEEF_01234567_89ABCDEF_DEADBEEF_DEADBEEF_01234567_89ABCDEF_DEADBEEF;
    blk = 64'hA5A5A5A5_01234567;
    for (int i = 0; i < 8; i++) write_key(3'(i), kc[255 - 32*i -: 32], 1'b1);
    core_lat = 0;
    s0 = starts;
    send_block(blk, 1'b1);
    recv_block(0, v, first);
    res = v;
    checks++;
    if (starts - s0 != 1) begin failures++; $display("FAIL known_starts got=%0d want=1", starts - s0); end
    checks++;
    if (st_data !== blk) begin failures++; $display("FAIL known_core_data got=%h want=%h", st_data, blk); end
    checks++;
    if (st_mode !== 1'b1) begin failures++; $display("FAIL known_mode got=%b want=1", st_mode); end
    checks++;
    if (st_key !== kc) begin failures++; $display("FAIL known_core_key got=%h want=%h", st_key, kc); end
    checks++;
    if (v !== cipher(blk, kc, 1'b1)) begin
      failures++; $display("FAIL known_output got=%h want=%h", v, cipher(blk, kc, 1'b1));
    end
    // one START cycle, core_lat+1 cycles until ready, then DRAIN
    checks++;
    if (first != core_lat + 2) begin failures++; $display("FAIL known_latency got=%0d want=%0d", first, core_lat + 2); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL known_idle busy got=%b want=0", busy); end
  endtask

  task automatic test_roundtrip(input logic [63:0] ct);
    logic [63:0] v;
    int first;
    core_lat = 3;
    send_block(ct, 1'b0);
    recv_block(0, v, first);
    checks++;
    if (st_mode !== 1'b0) begin failures++; $display("FAIL rt_mode got=%b want=0", st_mode); end
    checks++;
    if (v !== 64'hA5A5A5A5_01234567) begin
      failures++; $display("FAIL rt_output got=%h want=a5a5a5a501234567", v);
    end
  endtask

  task automatic test_busy();
    logic [63:0] blk, v;
    logic m;
    int s0, rel, first;
    blk = {$urandom, $urandom};
    m = 1'($urandom_range(0, 1));
    core_lat = 1;
    core_busy = 1'b1;
    s0 = starts;
    send_block(blk, m);
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (starts != s0 || busy !== 1'b1) begin
      failures++; $display("FAIL busy_hold starts=%0d want=%0d busy=%b", starts - s0, 0, busy);
    end
    rel = cyc;
    core_busy = 1'b0;
    recv_block(0, v, first);
    checks++;
    if (starts - s0 != 1) begin failures++; $display("FAIL busy_starts got=%0d want=1", starts - s0); end
    checks++;
    if (start_cyc != rel + 1) begin failures++; $display("FAIL busy_start_cycle got=%0d want=%0d", start_cyc, rel + 1); end
    checks++;
    if (v !== cipher(blk, key_vec(), m)) begin
      failures++; $display("FAIL busy_output got=%h want=%h", v, cipher(blk, key_vec(), m));
    end
  endtask

  task automatic test_timeout();
    logic [63:0] blk;
    int e0;
    bit seen;
    blk = {$urandom, $urandom};
    core_mute = 1'b1;
    core_lat = 0;
    e0 = errs;
    ov_seen = 1'b0;
    seen = 1'b0;
    send_block(blk, 1'b1);
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      #1;
      if (errs > e0) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (4) @(posedge clock);
    #1;
    core_mute = 1'b0;
    checks++;
    if (!seen || errs - e0 != 1) begin failures++; $display("FAIL to_err_count got=%0d want=1", errs - e0); end
    // WAIT entered at the edge after the start cycle; err follows 16 WAIT cycles
    checks++;
    if (err_cyc - start_cyc != 17) begin failures++; $display("FAIL to_err_cycle got=%0d want=17", err_cyc - start_cyc); end
    checks++;
    if (err_busy !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL to_idle busy_at_err=%b busy=%b want 0", err_busy, busy);
    end
    checks++;
    if (ov_seen) begin failures++; $display("FAIL to_out_valid got=1 want=0"); end
  endtask

  task automatic test_backpressure();
    logic [63:0] blk, v;
    int first;
    blk = {$urandom, $urandom};
    core_lat = 6;
    send_block(blk, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    write_key(3'd3, 32'hCAFEF00D, 1'b0);
    recv_block(1, v, first);
    checks++;
    if (v !== cipher(blk, key_vec(), 1'b1)) begin
      failures++; $display("FAIL bp_output got=%h want=%h", v, cipher(blk, key_vec(), 1'b1));
    end
    checks++;
    if (core_key !== key_vec()) begin failures++; $display("FAIL bp_key got=%h want=%h", core_key, key_vec()); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] blk, v;
    logic m;
    int first;
    bit ok;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), ok);
    do_reset();
    checks++;
    if (core_key !== 256'h0 || busy !== 1'b0) begin
      failures++; $display("FAIL rm_after_reset key=%h busy=%b want 0", core_key, busy);
    end
    blk = {$urandom, $urandom};
    m = 1'($urandom_range(0, 1));
    core_lat = 2;
    send_block(blk, m);
    recv_block(0, v, first);
    checks++;
    if (st_data !== blk) begin failures++; $display("FAIL rm_core_data got=%h want=%h", st_data, blk); end
    checks++;
    if (st_key !== 256'h0) begin failures++; $display("FAIL rm_core_key got=%h want=0", st_key); end
    checks++;
    if (v !== cipher(blk, 256'h0, m)) begin
      failures++; $display("FAIL rm_output got=%h want=%h", v, cipher(blk, 256'h0, m));
    end
    // reset while waiting on the core; its late ready must be ignored
    core_lat = 6;
    send_block({$urandom, $urandom}, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    do_reset();
    ov_seen = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || ov_seen) begin
      failures++; $display("FAIL rm_wait_reset busy=%b out_valid_seen=%b want 0", busy, ov_seen);
    end
    write_key(3'd0, 32'h13579BDF, 1'b1);
    checks++;
    if (core_key !== key_vec()) begin failures++; $display("FAIL rm_key_rewrite got=%h want=%h", core_key, key_vec()); end
  endtask

  task automatic test_random();
    logic [63:0] blk, v;
    logic m;
    int s0, first, nk;
    for (int it = 0; it < 8; it++) begin
      nk = $urandom_range(0, 2);
      for (int j = 0; j < nk; j++) write_key(3'($urandom_range(0, 7)), $urandom, 1'b1);
      blk = {$urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      core_lat = $urandom_range(0, 4);
      s0 = starts;
      send_block(blk, m);
      recv_block($urandom_range(0, 2), v, first);
      checks++;
      if (starts - s0 != 1 || st_data !== blk || st_key !== key_vec()) begin
        failures++;
        $display("FAIL rand_core it=%0d starts=%0d data=%h want=%h", it, starts - s0, st_data, blk);
      end
      checks++;
      if (v !== cipher(blk, key_vec(), m)) begin
        failures++; $display("FAIL rand_output it=%0d got=%h want=%h", it, v, cipher(blk, key_vec(), m));
      end
    end
  endtask

  initial begin
    logic [63:0] ct;
    test_reset();
    test_known(ct);
    test_roundtrip(ct);
    test_busy();
    test_timeout();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cripto_ctrl.md
CRIPTO_CTRL -- requirements
Module: cripto_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1024, is the number of WAIT cycles allowed before an error abort.
REQ-002 clock  input  1  is the single clock; all logic SHALL be rising-edge triggered on it.
REQ-003 reset  input  1  is a synchronous, active-high reset.
REQ-004 in_valid / in_data / in_ready are input, input [7:0] and output; together they form the plaintext/ciphertext byte input stream.
REQ-005 out_valid / out_data / out_ready are output, output [7:0] and input; together they form the result byte output stream.
REQ-006 enc_dec  input  1  selects the mode: 1 = encrypt, 0 = decrypt.
REQ-007 key_we / key_addr / key_word are input, input [2:0] and input [31:0]; they write the 256-bit key one word at a time.
REQ-008 core_start  output  1  is the start pulse to the cipher core.
REQ-009 core_enc_dec  output  1  is the mode sent to the cipher core.
REQ-010 core_data  output  64  is the block sent to the cipher core.
REQ-011 core_key  output  256  is the key sent to the cipher core.
REQ-012 core_busy / core_ready / core_result are input, input and input [63:0]; they are the cipher core status signals and result.
REQ-013 busy  output  1  is asserted whenever the state is not IDLE.
REQ-014 err  output  1  is a one-cycle timeout error pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, START, WAIT and DRAIN.
REQ-016 Transfers SHALL follow valid/ready rules: a byte moves only when valid and ready are both 1 in the same cycle, and valid SHALL NOT depend combinationally on ready.
REQ-017 in_ready SHALL be 1 in IDLE and LOAD and 0 in every other state.
REQ-018 Input bytes SHALL be packed MSB first: byte 0 goes to [63:56] and byte 7 goes to [7:0].
REQ-019 The first accepted byte in IDLE SHALL move the FSM to LOAD.
REQ-020 Acceptance of the 8th byte SHALL move the FSM to START in the next cycle.
REQ-021 At that 8th-byte acceptance, enc_dec SHALL be sampled into core_enc_dec and held until the next block.
REQ-022 In START, core_start SHALL be 1 for exactly one cycle, and only when core_busy is 0; the FSM then moves to WAIT.
REQ-023 In START with core_busy = 1, core_start SHALL stay 0 and the FSM SHALL remain in START.
REQ-024 In WAIT, when core_ready = 1 the block SHALL capture core_result and enter DRAIN in the next cycle.
REQ-025 core_ready SHALL be ignored in every state except WAIT.
REQ-026 In WAIT, a cycle counter SHALL increment each cycle.
REQ-027 If the WAIT counter reaches TIMEOUT with no core_ready, err SHALL pulse for one cycle, the block SHALL be discarded and the FSM SHALL return to IDLE.
REQ-028 If core_ready arrives in the same cycle as the timeout, the ready SHALL win and no err SHALL be raised.
REQ-029 In DRAIN, out_valid SHALL be 1 and out_data SHALL present the result bytes MSB first.
REQ-030 Each out_valid&&out_ready handshake SHALL advance one byte; out_data SHALL hold stable while stalled.
REQ-031 Acceptance of the 8th output byte SHALL move the FSM to IDLE.
REQ-032 The minimum latency from 8th input byte to first out_valid SHALL be 2 cycles plus the core latency.
REQ-033 Key word n SHALL be written to key[255-32n : 224-32n].
REQ-034 Key writes SHALL be accepted in IDLE and LOAD only; writes in START, WAIT or DRAIN SHALL be dropped silently.
REQ-035 core_key SHALL be driven directly from the key register.
REQ-036 core_data SHALL be driven from the assembled block register and SHALL stay stable from START through WAIT.
REQ-037 The byte counters SHALL be 3 bits wide and wrap 7->0 on the 8th transfer; no overflow state exists.

Reset
REQ-038 On reset, the FSM SHALL enter IDLE and the byte counters and WAIT counter SHALL clear.
REQ-039 On reset, the block register, result register, key register and core_enc_dec SHALL clear to 0.
REQ-040 Reset values of the remaining outputs SHALL be in_ready = 0 during reset and 1 after, with out_valid = 0, core_start = 0, busy = 0 and err = 0.
REQ-041 Reset SHALL take effect in any state, including mid-WAIT and mid-DRAIN; partial blocks and results SHALL be discarded.

Structure
REQ-042 A shared package SHALL hold the state enum, BLOCK_BYTES = 8, KEY_WORDS = 8, BLOCK_W = 64 and KEY_W = 256.
REQ-043 One sub-module, cripto_ctrl_ser, SHALL serialise the 64-bit result register into bytes with valid/ready.
REQ-044 The input packer and FSM SHALL reside in the top level.

Verification
REQ-045 Write key DEADBEEF0123456789ABCDEFDEADBEEFDEADBEEF0123456789ABCDEFDEADBEEF, feed A5 A5 A5 A5 01 23 45 67 with enc_dec = 1 -> core_data = A5A5A5A501234567, a single core_start pulse, core_enc_dec = 1, and the 8 output bytes equal the core result MSB first.
REQ-046 Run an encrypt result back with enc_dec = 0 and the same key, through the real core -> the output equals A5A5A5A501234567.
REQ-047 Hold core_busy = 1 for 5 cycles after the 8th input byte -> core_start stays 0 throughout and pulses once in the cycle after busy falls.
REQ-048 Use TIMEOUT = 16 with no core_ready -> err pulses once, 16 cycles into WAIT, then IDLE, busy = 0 and out_valid never asserts.
REQ-049 Toggle out_ready 1010 during DRAIN and write a key word mid-WAIT -> no byte is lost or duplicated and core_key is unchanged.
REQ-050 Assert reset after 4 input bytes, then send a full block -> the core receives only the post-reset 8 bytes and core_key = 0 until it is rewritten.
